// File: rtl/sram_unit_pkg.sv
// Shared types and helpers for the SRAM unit read/write datapaths.
// Exports: mode_e (element width mode), rd_meta_t (read-pipeline metadata),
// width/shift/lane-mask lookups and the lane_extract helper.
package sram_unit_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LANE_W = 3;

  // Encoding equals the address shift: element width is 8 >> mode.
  typedef enum logic [1:0] {
    MODE_C8 = 2'd0,
    MODE_C4 = 2'd1,
    MODE_C2 = 2'd2,
    MODE_C1 = 2'd3
  } mode_e;

  typedef struct packed {
    logic               vld;
    mode_e              mode;
    logic [LANE_W-1:0]  lane;
  } rd_meta_t;

  // Element width in bits.
  function automatic logic [3:0] width_of(mode_e m);
    logic [3:0] w;
    case (m)
      MODE_C4: w = 4'd4;
      MODE_C2: w = 4'd2;
      MODE_C1: w = 4'd1;
      default: w = 4'd8;
    endcase
    return w;
  endfunction

  // log2 of elements per word; element address >> shift gives the word.
  function automatic logic [1:0] shift_of(mode_e m);
    logic [1:0] s;
    case (m)
      MODE_C4: s = 2'd1;
      MODE_C2: s = 2'd2;
      MODE_C1: s = 2'd3;
      default: s = 2'd0;
    endcase
    return s;
  endfunction

  // Keeps only the low address bits that select the lane.
  function automatic logic [LANE_W-1:0] lane_mask(mode_e m);
    logic [LANE_W-1:0] k;
    case (m)
      MODE_C4: k = 3'b001;
      MODE_C2: k = 3'b011;
      MODE_C1: k = 3'b111;
      default: k = 3'b000;
    endcase
    return k;
  endfunction

  // Lane k occupies word[k*w +: w]; result is zero-extended to DATA_W.
  function automatic logic [DATA_W-1:0] lane_extract(logic [DATA_W-1:0] word,
                                                     mode_e m,
                                                     logic [LANE_W-1:0] lane);
    logic [DATA_W-1:0] res;
    res = word;
    case (m)
      MODE_C4: res = {4'b0, word[{lane[0], 2'b00} +: 4]};
      MODE_C2: res = {6'b0, word[{lane[1:0], 1'b0} +: 2]};
      MODE_C1: res = {7'b0, word[lane]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sram_unit_read_extractor_if.sv
// Request/response and SRAM-macro signals of the read extractor.
// slave : the extractor itself.
// master: the controller read port together with the SRAM macro data return.
interface sram_unit_read_extractor_if #(
  parameter int unsigned WORD_AW = 6
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_mode;
  logic [WORD_AW+2:0]   req_addr;
  logic                 sram_en;
  logic [WORD_AW-1:0]   sram_addr;
  logic [7:0]           sram_dout;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [7:0]           resp_data;

  modport slave (
    input  req_valid, req_mode, req_addr, sram_dout, resp_ready,
    output req_ready, sram_en, sram_addr, resp_valid, resp_data
  );

  modport master (
    output req_valid, req_mode, req_addr, sram_dout, resp_ready,
    input  req_ready, sram_en, sram_addr, resp_valid, resp_data
  );
endinterface

// File: rtl/sram_unit_resp_fifo.sv
// DEPTH x DATA_W synchronous FIFO with occupancy count.
// Ports: push/push_data write side, pop_req read side (ignored when empty),
// valid = not empty, rd_data = head entry (register-sourced), count = entries.
module sram_unit_resp_fifo
  import sram_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_req,
  output logic              valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              pop;

  // Pointer advance with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid   = (count_q != '0);
  assign pop     = pop_req && valid;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/sram_unit_read_extractor.sv
// Element-granular read front end for the 8-bit SRAM unit macro.
// Ports: clk, rst_n (async, active-low); bus (slave modport) carrying the
// request handshake (req_valid/req_ready/req_mode/req_addr), the SRAM read
// strobe/address/data (sram_en/sram_addr/sram_dout) and the response
// handshake (resp_valid/resp_ready/resp_data, zero-extended element).
module sram_unit_read_extractor
  import sram_unit_pkg::*;
#(
  parameter int unsigned WORD_AW  = 6,
  parameter int unsigned SRAM_LAT = 1,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sram_unit_read_extractor_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(DEPTH + SRAM_LAT + 1);

  mode_e              req_mode_e;
  logic [WORD_AW-1:0] req_word;
  logic [LANE_W-1:0]  req_lane;
  logic               accept;
  logic               ready_en_q;
  logic [WORD_AW-1:0] addr_q;
  rd_meta_t           meta_in;
  rd_meta_t           meta_q [SRAM_LAT];
  rd_meta_t           tail;
  logic [OCC_W-1:0]   inflight;
  logic [OCC_W-1:0]   occ;
  logic [CNT_W-1:0]   fifo_count;
  logic [DATA_W-1:0]  cap_data;

  // Element address -> (word, lane).
  always_comb begin
    req_mode_e = mode_e'(bus.req_mode);
    req_word   = WORD_AW'(bus.req_addr >> shift_of(req_mode_e));
    req_lane   = bus.req_addr[LANE_W-1:0] & lane_mask(req_mode_e);
    meta_in    = '{vld: accept, mode: req_mode_e, lane: req_lane};
  end

  // Every in-flight read already owns a FIFO slot, so capture never overflows.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(SRAM_LAT); i++)
      inflight = inflight + OCC_W'(meta_q[i].vld);
    occ           = inflight + OCC_W'(fifo_count);
    bus.req_ready = ready_en_q && (occ < OCC_W'(DEPTH));
  end

  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.sram_en   = accept;
  assign bus.sram_addr = accept ? req_word : addr_q;

  // Ready enable, held SRAM address and metadata delay line matching SRAM_LAT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      addr_q     <= '0;
      for (int i = 0; i < int'(SRAM_LAT); i++) meta_q[i] <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (accept) addr_q <= req_word;
      meta_q[0] <= meta_in;
      for (int i = 1; i < int'(SRAM_LAT); i++) meta_q[i] <= meta_q[i-1];
    end
  end

  assign tail     = meta_q[SRAM_LAT-1];
  assign cap_data = lane_extract(bus.sram_dout, tail.mode, tail.lane);

  sram_unit_resp_fifo #(.DEPTH(DEPTH)) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tail.vld),
    .push_data (cap_data),
    .pop_req   (bus.resp_ready),
    .valid     (bus.resp_valid),
    .rd_data   (bus.resp_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_sram_unit_read_extractor.sv
// Directed bench for sram_unit_read_extractor. u_dut uses the default
// DEPTH=2; u_dut_s uses DEPTH=3 (SRAM_LAT+2), the smallest buffer whose
// credit loop sustains one read per clock when pops free credits a cycle late.
module tb_sram_unit_read_extractor;
  localparam int unsigned WORD_AW = 6;
  localparam int unsigned LAT     = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] mem [64];

  always #5 clk = ~clk;

  sram_unit_read_extractor_if #(.WORD_AW(WORD_AW)) bus_a ();
  sram_unit_read_extractor_if #(.WORD_AW(WORD_AW)) bus_s ();

  sram_unit_read_extractor #(.WORD_AW(WORD_AW), .SRAM_LAT(LAT), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));

  sram_unit_read_extractor #(.WORD_AW(WORD_AW), .SRAM_LAT(LAT), .DEPTH(3)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));

  // SRAM macro models, one-cycle read latency.
  always @(posedge clk) if (bus_a.sram_en) bus_a.sram_dout <= mem[bus_a.sram_addr];
  always @(posedge clk) if (bus_s.sram_en) bus_s.sram_dout <= mem[bus_s.sram_addr];

  function automatic logic [7:0] pattern(int i);
    if (i == 5) return 8'hB6;
    return 8'((i * 19) ^ 'hF1);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One isolated read on u_dut: issue, then response at accept+2.
  task automatic read_one(string tag, logic [1:0] mode, logic [8:0] addr,
                          logic [5:0] exp_word, logic [7:0] exp_data);
    next_cycle();
    bus_a.req_valid = 1'b1;
    bus_a.req_mode  = mode;
    bus_a.req_addr  = addr;
    @(negedge clk);
    check({tag, "_en"},   32'(bus_a.sram_en),   32'h1);
    check({tag, "_addr"}, 32'(bus_a.sram_addr), 32'(exp_word));
    next_cycle();
    bus_a.req_valid = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, 32'(bus_a.resp_valid), 32'h0);
    next_cycle();
    @(negedge clk);
    check({tag, "_vld"},  32'(bus_a.resp_valid), 32'h1);
    check({tag, "_data"}, 32'(bus_a.resp_data),  32'(exp_data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = pattern(i);
    bus_a.req_valid = 1'b0; bus_a.req_mode = 2'd0; bus_a.req_addr = '0; bus_a.resp_ready = 1'b1;
    bus_s.req_valid = 1'b0; bus_s.req_mode = 2'd0; bus_s.req_addr = '0; bus_s.resp_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_resp_valid", 32'(bus_a.resp_valid), 32'h0);
    check("rst_resp_data",  32'(bus_a.resp_data),  32'h0);
    check("rst_sram_en",    32'(bus_a.sram_en),    32'h0);
    check("rst_sram_addr",  32'(bus_a.sram_addr),  32'h0);
    check("rst_req_ready",  32'(bus_a.req_ready),  32'h0);
    #2 rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("post_rst_ready",   32'(bus_a.req_ready), 32'h1);
    check("post_rst_ready_s", 32'(bus_s.req_ready), 32'h1);

    // Extraction on word 5 = 8'hB6 in every mode.
    read_one("c1_a42", 2'd3, 9'(42), 6'd5, 8'h01);
    read_one("c1_a40", 2'd3, 9'(40), 6'd5, 8'h00);
    read_one("c2_a23", 2'd2, 9'(23), 6'd5, 8'h02);
    read_one("c4_a11", 2'd1, 9'(11), 6'd5, 8'h0B);
    read_one("c4_a10", 2'd1, 9'(10), 6'd5, 8'h06);
    read_one("c8_a5",  2'd0, 9'(5),  6'd5, 8'hB6);

    // Backpressure: 4 cycles of req_valid with resp_ready low.
    next_cycle();
    bus_a.resp_ready = 1'b0;
    bus_a.req_valid = 1'b1; bus_a.req_mode = 2'd0; bus_a.req_addr = 9'(8);
    @(negedge clk);
    check("bp0_ready", 32'(bus_a.req_ready), 32'h1);
    next_cycle();
    bus_a.req_addr = 9'(9);
    @(negedge clk);
    check("bp1_ready", 32'(bus_a.req_ready), 32'h1);
    next_cycle();
    bus_a.req_addr = 9'(10);
    @(negedge clk);
    check("bp2_ready", 32'(bus_a.req_ready), 32'h0);
    check("bp2_en",    32'(bus_a.sram_en),   32'h0);
    check("bp2_hold",  32'(bus_a.sram_addr), 32'd9);
    next_cycle();
    bus_a.req_addr = 9'(11);
    @(negedge clk);
    check("bp3_ready", 32'(bus_a.req_ready), 32'h0);
    check("bp3_vld",   32'(bus_a.resp_valid), 32'h1);
    next_cycle();
    bus_a.req_valid = 1'b0;
    bus_a.resp_ready = 1'b1;
    @(negedge clk);
    check("bp4_ready", 32'(bus_a.req_ready),  32'h0);
    check("bp4_data",  32'(bus_a.resp_data),  32'(pattern(8)));
    next_cycle();
    @(negedge clk);
    check("bp5_ready", 32'(bus_a.req_ready),  32'h1);
    check("bp5_vld",   32'(bus_a.resp_valid), 32'h1);
    check("bp5_data",  32'(bus_a.resp_data),  32'(pattern(9)));
    next_cycle();
    @(negedge clk);
    check("bp6_vld",   32'(bus_a.resp_valid), 32'h0);

    // Pop and accept in the same cycle with one buffered entry.
    next_cycle();
    bus_a.resp_ready = 1'b0;
    bus_a.req_valid = 1'b1; bus_a.req_mode = 2'd0; bus_a.req_addr = 9'(1);
    next_cycle();
    bus_a.req_valid = 1'b0;
    next_cycle();
    bus_a.resp_ready = 1'b1;
    bus_a.req_valid = 1'b1; bus_a.req_addr = 9'(2);
    @(negedge clk);
    check("pa_ready", 32'(bus_a.req_ready),  32'h1);
    check("pa_vld",   32'(bus_a.resp_valid), 32'h1);
    check("pa_data",  32'(bus_a.resp_data),  32'(pattern(1)));
    next_cycle();
    bus_a.req_valid = 1'b0;
    @(negedge clk);
    check("pa_gap",   32'(bus_a.resp_valid), 32'h0);
    next_cycle();
    @(negedge clk);
    check("pa_vld2",  32'(bus_a.resp_valid), 32'h1);
    check("pa_data2", 32'(bus_a.resp_data),  32'(pattern(2)));
    next_cycle();
    @(negedge clk);
    check("pa_nodup", 32'(bus_a.resp_valid), 32'h0);

    // Reset with one response buffered and one read in flight.
    next_cycle();
    bus_a.resp_ready = 1'b0;
    bus_a.req_valid = 1'b1; bus_a.req_mode = 2'd0; bus_a.req_addr = 9'(5);
    next_cycle();
    bus_a.req_addr = 9'(6);
    @(negedge clk);
    check("rm_ready", 32'(bus_a.req_ready), 32'h1);
    next_cycle();
    bus_a.req_valid = 1'b0;
    check("rm_vld_pre", 32'(bus_a.resp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rm_vld_rst",   32'(bus_a.resp_valid), 32'h0);
    check("rm_ready_rst", 32'(bus_a.req_ready),  32'h0);
    next_cycle();
    @(negedge clk);
    #2 rst_n = 1'b1;
    bus_a.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check("rm_stale", 32'(bus_a.resp_valid), 32'h0);
    end
    read_one("rm_c1_a0", 2'd3, 9'(0), 6'd0, 8'h01);

    // Streaming on the DEPTH=3 instance: 16 back-to-back c8 reads.
    for (int i = 0; i < 18; i++) begin
      next_cycle();
      if (i < 16) begin
        bus_s.req_valid = 1'b1; bus_s.req_mode = 2'd0; bus_s.req_addr = 9'(i);
      end else begin
        bus_s.req_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 16) check($sformatf("st_ready_%0d", i), 32'(bus_s.req_ready), 32'h1);
      if (i >= 2) begin
        check($sformatf("st_vld_%0d", i - 2),  32'(bus_s.resp_valid), 32'h1);
        check($sformatf("st_data_%0d", i - 2), 32'(bus_s.resp_data),  32'(pattern(i - 2)));
      end else begin
        check($sformatf("st_idle_%0d", i), 32'(bus_s.resp_valid), 32'h0);
      end
    end
    next_cycle();
    @(negedge clk);
    check("st_drained", 32'(bus_s.resp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
